// File: rtl/dif_r2sdf_stage.sv
// Radix-2 single-path delay-feedback DIF stage: D-deep feedback FIFO, fill phase then butterfly phase.
// Twiddle products wrap to DATA_WIDTH_OUT by default; define DIF_R2SDF_SAT_EN to saturate them instead.

module dif_r2sdf_stage #(
   parameter int DATA_WIDTH_IN  = 10,
   parameter int DATA_WIDTH_OUT = 11,
   parameter int FIFO_DEPTH     = 4,
   parameter int TWIDDLE_RANK   = 8
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               din_valid,
   input  logic signed [DATA_WIDTH_IN-1:0]    din_real,
   input  logic signed [DATA_WIDTH_IN-1:0]    din_imag,
   output logic        [$clog2(FIFO_DEPTH)-1:0] tw_addr,
   input  logic signed [TWIDDLE_RANK+1:0]     tw_real,
   input  logic signed [TWIDDLE_RANK+1:0]     tw_imag,
   output logic signed [DATA_WIDTH_OUT-1:0]   dout_real,
   output logic signed [DATA_WIDTH_OUT-1:0]   dout_imag,
   output logic                               dout_valid,
   output logic                               sof_out
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int OW = DATA_WIDTH_OUT;
   localparam int PW = DATA_WIDTH_OUT + TWIDDLE_RANK + 3;
   localparam logic signed [PW-1:0] ROUND = PW'(2 ** (TWIDDLE_RANK - 1));
`ifdef DIF_R2SDF_SAT_EN
   localparam logic signed [PW-1:0] SAT_MAX = PW'(2 ** (OW - 1) - 1);
   localparam logic signed [PW-1:0] SAT_MIN = -SAT_MAX - PW'(1);
`endif

   function automatic logic signed [OW-1:0] f_reduce(input logic signed [PW-1:0] v);
`ifdef DIF_R2SDF_SAT_EN
      if (v > SAT_MAX) return OW'(SAT_MAX);
      if (v < SAT_MIN) return OW'(SAT_MIN);
      return OW'(v);
`else
      return OW'(v);
`endif
   endfunction

   logic [CW-1:0]          r_cnt;
   logic                   r_primed;
   logic signed [OW-1:0]   r_fifo_re [FIFO_DEPTH];
   logic signed [OW-1:0]   r_fifo_im [FIFO_DEPTH];
   logic signed [OW-1:0]   r_dout_re, r_dout_im;
   logic                   r_dout_valid, r_sof;

   logic                   w_phase;
   logic [AW-1:0]          w_idx;
   logic signed [OW-1:0]   w_a_re, w_a_im, w_b_re, w_b_im;
   logic signed [OW-1:0]   w_sum_re, w_sum_im, w_dif_re, w_dif_im;
   logic signed [PW-1:0]   w_x_re, w_x_im, w_c, w_s, w_p_re, w_p_im;
   logic signed [OW-1:0]   w_t_re, w_t_im;

   assign w_phase = r_cnt[CW-1];
   assign w_idx   = r_cnt[AW-1:0];
   assign tw_addr = w_phase ? '0 : w_idx;

   // a is the oldest FIFO entry: a fill sample in phase 1, a stored difference in phase 0
   assign w_a_re   = r_fifo_re[FIFO_DEPTH-1];
   assign w_a_im   = r_fifo_im[FIFO_DEPTH-1];
   assign w_b_re   = OW'(din_real);
   assign w_b_im   = OW'(din_imag);
   assign w_sum_re = w_a_re + w_b_re;
   assign w_sum_im = w_a_im + w_b_im;
   assign w_dif_re = w_a_re - w_b_re;
   assign w_dif_im = w_a_im - w_b_im;

   assign w_x_re = PW'(w_a_re);
   assign w_x_im = PW'(w_a_im);
   assign w_c    = PW'(tw_real);
   assign w_s    = PW'(tw_imag);
   assign w_p_re = (w_x_re * w_c - w_x_im * w_s + ROUND) >>> TWIDDLE_RANK;
   assign w_p_im = (w_x_im * w_c + w_x_re * w_s + ROUND) >>> TWIDDLE_RANK;
   assign w_t_re = f_reduce(w_p_re);
   assign w_t_im = f_reduce(w_p_im);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt        <= '0;
         r_primed     <= 1'b0;
         r_dout_re    <= '0;
         r_dout_im    <= '0;
         r_dout_valid <= 1'b0;
         r_sof        <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_fifo_re[i] <= '0;
            r_fifo_im[i] <= '0;
         end
      end else begin
         r_dout_valid <= din_valid & r_primed;
         if (din_valid) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(FIFO_DEPTH - 1)) r_primed <= 1'b1;
            r_sof        <= (r_cnt == CW'(FIFO_DEPTH));
            r_fifo_re[0] <= w_phase ? w_dif_re : w_b_re;
            r_fifo_im[0] <= w_phase ? w_dif_im : w_b_im;
            for (int i = 1; i < FIFO_DEPTH; i++) begin
               r_fifo_re[i] <= r_fifo_re[i-1];
               r_fifo_im[i] <= r_fifo_im[i-1];
            end
            r_dout_re <= w_phase ? w_sum_re : w_t_re;
            r_dout_im <= w_phase ? w_sum_im : w_t_im;
         end
      end
   end

   assign dout_real  = r_dout_re;
   assign dout_imag  = r_dout_im;
   assign dout_valid = r_dout_valid;
   assign sof_out    = r_sof;

endmodule

// File: doc/dif_r2sdf_stage.md
DIF_R2SDF_STAGE -- requirements
Module: dif_r2sdf_stage

Interface
REQ-001 Parameter DATA_WIDTH_IN, default 10, SHALL set the input sample width (signed, per component).
REQ-002 Parameter DATA_WIDTH_OUT, default 11, SHALL set the output and FIFO sample width; it SHALL be at least DATA_WIDTH_IN+1.
REQ-003 Parameter FIFO_DEPTH, default 4, SHALL set the delay depth D; D SHALL be a power of two and at least 2. The frame length is 2D.
REQ-004 Parameter TWIDDLE_RANK, default 8, SHALL set the number of twiddle fraction bits R.
REQ-005 Port clk, input, 1 bit: the single clock; all logic SHALL be rising-edge clocked.
REQ-006 Port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-007 Port din_valid, input, 1 bit: a sample is accepted on every clock edge where it is high.
REQ-008 Ports din_real and din_imag, input, DATA_WIDTH_IN bits each, signed: input sample.
REQ-009 Port tw_addr, output, log2(D) bits: twiddle index k, combinational from internal state.
REQ-010 Ports tw_real and tw_imag, input, R+2 bits each, signed: coefficient for tw_addr, combinational in the same cycle; value = round(cos(pi*k/D)*2^R) and -round(sin(pi*k/D)*2^R).
REQ-011 Ports dout_real and dout_imag, output, DATA_WIDTH_OUT bits each, signed, registered: output sample.
REQ-012 Port dout_valid, output, 1 bit, registered: dout holds a valid sample.
REQ-013 Port sof_out, output, 1 bit, registered: marks the first valid output of each frame.

Function
REQ-014 A counter cnt (log2(2D) bits) SHALL increment on each accepted sample and wrap from 2D-1 to 0; the phase is the counter MSB, and the index j is the low log2(D) bits.
REQ-015 Phase 0 (fill): the FIFO SHALL push the sign-extended din; dout SHALL be FIFO_out*W, where W = tw_real + j*tw_imag.
REQ-016 Phase 1 (butterfly): with a = FIFO_out and b = din, dout SHALL be a+b and the FIFO SHALL push a-b.
REQ-017 In phase 0, tw_addr SHALL equal j; in phase 1, tw_addr SHALL be 0.
REQ-018 Butterfly sums and differences SHALL be computed at DATA_WIDTH_OUT width with no overflow possible.
REQ-019 Twiddle product (component-wise):
- Real part = x*c - y*s; imaginary part = y*c + x*s.
- Each full-precision result SHALL be rounded by adding 2^(R-1), then arithmetic-shifted right by R.
- The result SHALL then be reduced to DATA_WIDTH_OUT bits per REQ-030.
REQ-020 dout update: dout SHALL update one clock after acceptance, so latency is 1 cycle from din to dout.
REQ-021 dout_valid SHALL be high in the cycle after an accepted sample, once the block is primed.
REQ-022 A primed flag SHALL set when cnt first wraps from D-1 to D after reset, and stay set until reset. dout_valid SHALL be low for the first D accepted samples.
REQ-023 sof_out SHALL pulse with the output produced at cnt == D.
REQ-024 When din_valid is low, the block SHALL stall:
- cnt, the FIFO, dout and sof_out SHALL hold their values.
- dout_valid SHALL go low on the next edge.
- The output sequence SHALL be identical to the same input stream with no stall.
REQ-025 The FIFO SHALL advance only on accepted samples and shall have exactly D entries.

Reset
REQ-026 While rst_n is low at a clock edge, the following SHALL be cleared to zero:
- cnt, the primed flag and every FIFO entry;
- dout_real, dout_imag, dout_valid and sof_out.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame. The next accepted sample SHALL be treated as frame index 0 and as unprimed.
REQ-028 If rst_n and din_valid are both active at the same edge, reset SHALL take priority and the sample SHALL be dropped.

Configuration
REQ-029 Macro DIF_R2SDF_SAT_EN SHALL select how twiddle products are reduced to DATA_WIDTH_OUT bits.
REQ-030 With DIF_R2SDF_SAT_EN defined, a rounded product outside the signed DATA_WIDTH_OUT range SHALL saturate to the maximum or minimum value. Without the macro, it SHALL wrap, i.e. keep the low DATA_WIDTH_OUT bits.

Verification
All scenarios use defaults (D=4, IN=10, OUT=11, R=8) with an ideal coefficient ROM.
REQ-031 Reset: hold rst_n low for 3 edges -> all outputs 0 and dout_valid 0.
REQ-032 Constant input 100+j0, 16 samples back-to-back:
- Samples 5-8 -> dout 200 and tw_addr 0; sof_out is high only on the first of these.
- Samples 9-12 -> dout 0, with tw_addr stepping 0,1,2,3.
REQ-033 Impulse 256+j0 at frame index 0, all other samples 0, followed by a zero frame:
- Sums -> 256,0,0,0.
- Differences -> 256,0,0,0 (W^0 = 256).
REQ-034 Saturation case:
- Stimulus: a = 511+j511 at frame index 1; b = -512-j512 at frame index 5; coefficient 181-j181 at k=1.
- With the macro defined, the twiddled output at k=1 -> 1023+j0.
- Without the macro, the same output -> -601+j0.
REQ-035 Stall: repeat REQ-032 with din_valid low for 3 cycles after sample 6 -> dout_valid is low for those cycles, dout is held, and the value sequence is unchanged.
REQ-036 Mid-frame reset: assert reset after sample 6, then replay REQ-032 -> its responses match exactly.
